// File: rtl/fir_pkg.sv
// Shared state encoding and default parameters for the FIR sequencing controller.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_N_TAPS  = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_OUT_W   = 14;
  localparam int DEF_FIR_LAT = 2;

endpackage

// File: rtl/fir_vld_pipe.sv
// Valid-bit delay line matching the filter latency; one bit per cycle in flight.
module fir_vld_pipe
  import fir_pkg::*;
#(
  parameter int DEPTH = DEF_FIR_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  output logic vld_out,
  output logic empty
);

  logic [DEPTH-1:0] stg_q;
  logic [DEPTH-1:0] stg_d;

  // Shift in the new valid; empty looks at the next contents so the caller can
  // leave its drain state on the same edge the final result is captured.
  always_comb begin
    stg_d = (stg_q << 1'b1) | DEPTH'(vld_in);
    empty = (stg_d == {DEPTH{1'b0}});
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= {DEPTH{1'b0}};
    end else begin
      stg_q <= stg_d;
    end
  end

  assign vld_out = stg_q[DEPTH-1];

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencing controller: routes host bytes to the filter as coefficients or
// samples and re-times the filter output with a latency-matched valid pipeline.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int N_TAPS  = DEF_N_TAPS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int FIR_LAT = DEF_FIR_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              cmd_load,
  input  logic              cmd_run,
  input  logic              cmd_stop,
  output logic [DATA_W-1:0] fir_x_n,
  output logic              fir_valid,
  output logic              fir_set_coeffs,
  input  logic [OUT_W-1:0]  fir_y_n,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              coeffs_ok,
  output logic              busy,
  output logic              err
);

  localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  state_t             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic               busy_q, busy_d;
  logic               host_ready_q, host_ready_d;
  logic [DATA_W-1:0]  fir_x_q, fir_x_d;
  logic               fir_valid_q, fir_valid_d;
  logic               fir_set_q, fir_set_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               coeffs_ok_q, coeffs_ok_d;
  logic               err_q, err_d;

  logic accept_s;
  logic pipe_in_s;
  logic pipe_out_s;
  logic pipe_empty_s;

  assign accept_s  = host_valid && host_ready_q;
  // Only sample writes produce filter results; coefficient writes are excluded.
  assign pipe_in_s = fir_valid_q && !fir_set_q;

  fir_vld_pipe #(.DEPTH(FIR_LAT)) u_vld_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (pipe_in_s),
    .vld_out (pipe_out_s),
    .empty   (pipe_empty_s)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    coeffs_ok_d = coeffs_ok_q;
    err_d       = 1'b0;
    fir_valid_d = accept_s;
    fir_set_d   = 1'b0;
    if (accept_s) begin
      fir_x_d = host_data;
    end else begin
      fir_x_d = fir_x_q;
    end

    case (state_q)
      IDLE: begin
        if (cmd_load) begin
          state_d     = LOAD;
          tap_d       = {TAP_W{1'b0}};
          coeffs_ok_d = 1'b0;
        end else if (cmd_run) begin
          if (coeffs_ok_q) begin
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        fir_set_d = accept_s;
        if (accept_s) begin
          if (tap_q == TAP_W'(N_TAPS - 1)) begin
            state_d     = IDLE;
            tap_d       = {TAP_W{1'b0}};
            coeffs_ok_d = 1'b1;
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end else begin
          tap_d = tap_q;
        end
      end
      RUN: begin
        if (cmd_stop) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d       = (state_d != IDLE);
    host_ready_d = (state_d == LOAD) || (state_d == RUN);
    out_valid_d  = pipe_out_s;
    if (pipe_out_s) begin
      out_data_d = fir_y_n;
    end else begin
      out_data_d = out_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tap_q        <= {TAP_W{1'b0}};
      busy_q       <= 1'b0;
      host_ready_q <= 1'b0;
      fir_x_q      <= {DATA_W{1'b0}};
      fir_valid_q  <= 1'b0;
      fir_set_q    <= 1'b0;
      out_data_q   <= {OUT_W{1'b0}};
      out_valid_q  <= 1'b0;
      coeffs_ok_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      busy_q       <= busy_d;
      host_ready_q <= host_ready_d;
      fir_x_q      <= fir_x_d;
      fir_valid_q  <= fir_valid_d;
      fir_set_q    <= fir_set_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      coeffs_ok_q  <= coeffs_ok_d;
      err_q        <= err_d;
    end
  end

  assign host_ready     = host_ready_q;
  assign fir_x_n        = fir_x_q;
  assign fir_valid      = fir_valid_q;
  assign fir_set_coeffs = fir_set_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign coeffs_ok      = coeffs_ok_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: stub FIR, behavioural reference model and per-cycle compare.
module tb_fir_ctrl;
  localparam int N_TAPS = 4, DATA_W = 8, OUT_W = 14, FIR_LAT = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] host_data = 8'h00;
  logic host_valid = 1'b0, cmd_load = 1'b0, cmd_run = 1'b0, cmd_stop = 1'b0;
  logic host_ready, fir_valid, fir_set_coeffs, out_valid, coeffs_ok, busy, err;
  logic [DATA_W-1:0] fir_x_n;
  logic [OUT_W-1:0] fir_y_n, out_data;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fir_ctrl #(.N_TAPS(N_TAPS), .DATA_W(DATA_W), .OUT_W(OUT_W), .FIR_LAT(FIR_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
    .fir_x_n(fir_x_n), .fir_valid(fir_valid), .fir_set_coeffs(fir_set_coeffs),
    .fir_y_n(fir_y_n), .out_data(out_data), .out_valid(out_valid),
    .coeffs_ok(coeffs_ok), .busy(busy), .err(err));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stub FIR: coefficient table plus sample history, result valid FIR_LAT cycles later.
  logic [7:0] st_coef [N_TAPS];
  logic [7:0] st_hist [N_TAPS];
  logic [OUT_W-1:0] st_dly [FIR_LAT];
  int st_idx, st_acc;
  assign fir_y_n = st_dly[FIR_LAT-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin st_coef[i] <= 8'h00; st_hist[i] <= 8'h00; end
      for (int i = 0; i < FIR_LAT; i++) st_dly[i] <= '0;
      st_idx <= 0;
    end else begin
      if (fir_valid && fir_set_coeffs) begin
        st_coef[st_idx] <= fir_x_n;
        st_idx <= (st_idx + 1) % N_TAPS;
      end
      st_acc = int'(fir_x_n) * int'(st_coef[0]);
      for (int i = 1; i < N_TAPS; i++) st_acc += int'(st_hist[i-1]) * int'(st_coef[i]);
      st_dly[0] <= (fir_valid && !fir_set_coeffs) ? OUT_W'(st_acc) : 14'h2AAA;
      for (int i = 1; i < FIR_LAT; i++) st_dly[i] <= st_dly[i-1];
      if (fir_valid && !fir_set_coeffs) begin
        st_hist[0] <= fir_x_n;
        for (int i = 1; i < N_TAPS; i++) st_hist[i] <= st_hist[i-1];
      end
    end
  end

  // Reference model: mode, coefficient set, sample history and a queue of due results.
  typedef struct { int due; logic [OUT_W-1:0] y; } res_t;
  res_t pend_q[$];
  res_t m_r;
  int m_mode = M_IDLE, m_cnt = 0, m_cyc = 0, m_y;
  logic m_acc;
  logic [7:0] m_coef [N_TAPS];
  logic [7:0] m_hist [N_TAPS];
  logic exp_ready = 1'b0, exp_fv = 1'b0, exp_set = 1'b0, exp_ov = 1'b0;
  logic exp_err = 1'b0, exp_busy = 1'b0, exp_ok = 1'b0;
  logic [7:0] exp_x = 8'h00;
  logic [OUT_W-1:0] exp_od = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_cnt = 0; pend_q.delete();
      for (int i = 0; i < N_TAPS; i++) begin m_coef[i] = 8'h00; m_hist[i] = 8'h00; end
      exp_ready = 0; exp_fv = 0; exp_set = 0; exp_ov = 0; exp_err = 0; exp_busy = 0;
      exp_ok = 0; exp_x = 8'h00; exp_od = '0;
    end else begin
      m_cyc++;
      m_acc   = host_valid && exp_ready;
      exp_fv  = m_acc;
      exp_set = m_acc && (m_mode == M_LOAD);
      if (m_acc) exp_x = host_data;
      exp_err = 0;
      exp_ov  = 0;
      if (pend_q.size() > 0 && pend_q[0].due == m_cyc) begin
        exp_ov = 1; exp_od = pend_q[0].y; void'(pend_q.pop_front());
      end
      case (m_mode)
        M_IDLE:
          if (cmd_load) begin m_mode = M_LOAD; m_cnt = 0; exp_ok = 0; end
          else if (cmd_run) begin
            if (exp_ok) m_mode = M_RUN; else exp_err = 1;
          end
        M_LOAD:
          if (m_acc) begin
            m_coef[m_cnt] = host_data;
            m_cnt++;
            if (m_cnt == N_TAPS) begin m_mode = M_IDLE; exp_ok = 1; end
          end
        M_RUN: begin
          if (m_acc) begin
            for (int i = N_TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = host_data;
            m_y = 0;
            for (int i = 0; i < N_TAPS; i++) m_y += int'(m_coef[i]) * int'(m_hist[i]);
            m_r.due = m_cyc + FIR_LAT + 1;
            m_r.y = OUT_W'(m_y);
            pend_q.push_back(m_r);
          end
          if (cmd_stop) m_mode = M_DRAIN;
        end
        M_DRAIN:
          if (pend_q.size() == 0) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      exp_busy  = (m_mode != M_IDLE);
      exp_ready = (m_mode == M_LOAD) || (m_mode == M_RUN);
    end
  end

  // Compare process plus event logs used by the directed literal checks.
  logic [7:0] set_log[$];
  logic [OUT_W-1:0] out_log[$];
  int out_cyc[$];
  int n_ov = 0;

  always @(negedge clk) begin
    chk("host_ready", 32'(host_ready), 32'(exp_ready));
    chk("fir_valid", 32'(fir_valid), 32'(exp_fv));
    chk("fir_set_coeffs", 32'(fir_set_coeffs), 32'(exp_set));
    chk("fir_x_n", 32'(fir_x_n), 32'(exp_x));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("out_data", 32'(out_data), 32'(exp_od));
    chk("coeffs_ok", 32'(coeffs_ok), 32'(exp_ok));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("err", 32'(err), 32'(exp_err));
    if (fir_set_coeffs) set_log.push_back(fir_x_n);
    if (out_valid) begin out_log.push_back(out_data); out_cyc.push_back(m_cyc); n_ov++; end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(host_ready), 32'h0);
    chk({nm, "_x"}, 32'(fir_x_n), 32'h0);
    chk({nm, "_fv"}, 32'(fir_valid), 32'h0);
    chk({nm, "_set"}, 32'(fir_set_coeffs), 32'h0);
    chk({nm, "_od"}, 32'(out_data), 32'h0);
    chk({nm, "_ov"}, 32'(out_valid), 32'h0);
    chk({nm, "_ok"}, 32'(coeffs_ok), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin step(); n++; end
    if (busy) chk({nm, "_timeout"}, 32'(busy), 32'h0);
    step();
  endtask

  int acc_edge, n0, dcnt;

  initial begin
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Rejected run: one-cycle err, no state change.
    cmd_run = 1'b1; step(); cmd_run = 1'b0;
    chk("reject_err", 32'(err), 32'h1);
    chk("reject_busy", 32'(busy), 32'h0);
    step();
    chk("reject_err_once", 32'(err), 32'h0);

    // Coefficient load 1,2,3,4 back-to-back.
    set_log.delete(); n0 = n_ov;
    cmd_load = 1'b1; step(); cmd_load = 1'b0;
    host_valid = 1'b1;
    for (int b = 1; b <= 4; b++) begin host_data = 8'(b); step(); end
    host_valid = 1'b0;
    chk("load_ready_low", 32'(host_ready), 32'h0);
    chk("load_coeffs_ok", 32'(coeffs_ok), 32'h1);
    step(); step();
    chk("load_writes", 32'(set_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("load_x", 32'(set_log[i]), 32'(i + 1));
    chk("load_no_out", 32'(n_ov - n0), 32'd0);

    // Impulse through the loaded taps.
    out_log.delete(); out_cyc.delete();
    cmd_run = 1'b1; step(); cmd_run = 1'b0;
    host_valid = 1'b1; host_data = 8'h01; step(); acc_edge = m_cyc;
    host_data = 8'h00; repeat (4) step();
    host_valid = 1'b0;
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    wait_idle("impulse");
    chk("impulse_count", 32'(out_log.size()), 32'd5);
    chk("impulse_y0", 32'(out_log[0]), 32'd1);
    chk("impulse_y1", 32'(out_log[1]), 32'd2);
    chk("impulse_y2", 32'(out_log[2]), 32'd3);
    chk("impulse_y3", 32'(out_log[3]), 32'd4);
    chk("impulse_y4", 32'(out_log[4]), 32'd0);
    // Edge that accepts the byte to the edge that raises out_valid.
    chk("impulse_latency", 32'(out_cyc[0] - acc_edge), 32'(FIR_LAT + 1));

    // Stop in the same cycle as an accepted 0x7F.
    out_log.delete();
    cmd_run = 1'b1; step(); cmd_run = 1'b0;
    host_valid = 1'b1; host_data = 8'h11; step();
    host_data = 8'h7F; cmd_stop = 1'b1; step();
    host_valid = 1'b0; cmd_stop = 1'b0;
    dcnt = 0;
    while (busy && dcnt < 20) begin dcnt++; step(); end
    step();
    chk("drain_len", 32'(dcnt), 32'(FIR_LAT + 1));
    chk("stop_count", 32'(out_log.size()), 32'd2);
    chk("stop_y_11", 32'(out_log[0]), 32'd17);
    chk("stop_y_7f", 32'(out_log[1]), 32'd161);

    // Load and run together, host_valid toggling: load wins, gaps add nothing.
    set_log.delete();
    cmd_load = 1'b1; cmd_run = 1'b1; step(); cmd_load = 1'b0; cmd_run = 1'b0;
    for (int j = 0; j < 8; j++) begin
      host_valid = (j % 2 == 0); host_data = 8'(8'h20 + j); step();
    end
    host_valid = 1'b0; step(); step();
    chk("toggle_writes", 32'(set_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("toggle_x", 32'(set_log[i]), 32'(8'h20 + 2 * i));
    chk("toggle_ok", 32'(coeffs_ok), 32'h1);

    // Reset with two results in flight.
    cmd_run = 1'b1; step(); cmd_run = 1'b0;
    host_valid = 1'b1; host_data = 8'h03; step();
    host_data = 8'h05; step(); host_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk_all_zero("midrst");
    step(); step(); rst_n = 1'b1; n0 = n_ov;
    repeat (6) step();
    chk("midrst_no_out", 32'(n_ov - n0), 32'd0);
    chk("midrst_ok", 32'(coeffs_ok), 32'h0);
    cmd_run = 1'b1; step(); cmd_run = 1'b0;
    chk("midrst_err", 32'(err), 32'h1);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      host_valid = ($urandom_range(0, 9) < 6);
      host_data  = 8'($urandom);
      cmd_load   = ($urandom_range(0, 19) == 0);
      cmd_run    = ($urandom_range(0, 7) == 0);
      cmd_stop   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end else begin
        step();
      end
    end
    host_valid = 1'b0; cmd_load = 1'b0; cmd_run = 1'b0;
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    host_valid = 1'b1; host_data = 8'h00;
    repeat (N_TAPS + 1) step();
    host_valid = 1'b0;
    wait_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
